// File: rtl/r_fifo.sv
// ---------------------------------------------------------------------------
// r_fifo: AXI R-channel return buffer for the crossbar.
//
// It buffers up to DEPTH read-data beats from the slave side and returns them
// in order to the master side. A small queue of expected burst lengths (ARLEN),
// filled from the address side, is used to check every RLAST. Any disagreement
// sets a sticky error flag. Beats are always forwarded unmodified.
//
// Ports:
//   ACLK, ARESET          clock (rising edge), asynchronous active-high reset
//   S_R*                  incoming beat (ID, data, response, last, valid/ready)
//   M_R*                  head beat toward the master (valid/ready)
//   len_push, len_in      enqueue an expected ARLEN (beats minus 1)
//   len_full              length queue full
//   count                 beats currently buffered
//   beat_cnt              beats popped so far in the current burst
//   last_err              sticky burst-length mismatch flag
//
// Optional feature, macro R_FIFO_BYPASS_EN:
//   When the buffer is empty, the incoming beat is also shown on M_R* in the
//   same cycle. If M_RREADY is high, the beat is consumed directly and is not
//   written to storage. With the macro undefined, there is a minimum latency
//   of one cycle and no combinational path from S_R* to M_R*.
// ---------------------------------------------------------------------------
module r_fifo #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     S_RID,
    input  logic [DATA_WIDTH-1:0]   S_RDATA,
    input  logic [1:0]              S_RRESP,
    input  logic                    S_RLAST,
    input  logic                    S_RVALID,
    output logic                    S_RREADY,
    output logic [ID_WIDTH-1:0]     M_RID,
    output logic [DATA_WIDTH-1:0]   M_RDATA,
    output logic [1:0]              M_RRESP,
    output logic                    M_RLAST,
    output logic                    M_RVALID,
    input  logic                    M_RREADY,
    input  logic                    len_push,
    input  logic [LEN_WIDTH-1:0]    len_in,
    output logic                    len_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic [LEN_WIDTH-1:0]    beat_cnt,
    output logic                    last_err
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned LPW = $clog2(LEN_DEPTH);
    localparam int unsigned LCW = LPW + 1;

    // Beat storage
    logic [ID_WIDTH-1:0]   r_rid   [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata [DEPTH];
    logic [1:0]            r_rresp [DEPTH];
    logic                  r_rlast [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    // Expected-length queue
    logic [LEN_WIDTH-1:0]  r_len_mem [LEN_DEPTH];
    logic [LPW-1:0]        r_len_wr;
    logic [LPW-1:0]        r_len_rd;
    logic [LCW-1:0]        r_len_count;

    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic                  r_last_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_s_ready;
    logic                  w_bypass;
    logic                  w_m_valid;
    logic [ID_WIDTH-1:0]   w_hd_id;
    logic [DATA_WIDTH-1:0] w_hd_data;
    logic [1:0]            w_hd_resp;
    logic                  w_hd_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_buf_pop;
    logic                  w_len_full;
    logic                  w_len_empty;
    logic                  w_len_push;
    logic                  w_len_pop;
    logic [LEN_WIDTH-1:0]  w_len_exp;
    logic                  w_err_now;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_s_ready = !ARESET && !w_full;

`ifdef R_FIFO_BYPASS_EN
    logic w_use_s;
    // The incoming beat becomes the head only while the buffer is empty. It is
    // forced to zero in reset so that M_R* read 0.
    assign w_use_s   = w_empty && !ARESET;
    assign w_bypass  = w_use_s && S_RVALID && M_RREADY;
    assign w_m_valid = !w_empty || (S_RVALID && !ARESET);
    assign w_hd_id   = w_use_s ? S_RID   : (w_empty ? '0   : r_rid[r_rd_ptr]);
    assign w_hd_data = w_use_s ? S_RDATA : (w_empty ? '0   : r_rdata[r_rd_ptr]);
    assign w_hd_resp = w_use_s ? S_RRESP : (w_empty ? '0   : r_rresp[r_rd_ptr]);
    assign w_hd_last = w_use_s ? S_RLAST : (w_empty ? 1'b0 : r_rlast[r_rd_ptr]);
`else
    assign w_bypass  = 1'b0;
    assign w_m_valid = !w_empty;
    assign w_hd_id   = r_rid[r_rd_ptr];
    assign w_hd_data = r_rdata[r_rd_ptr];
    assign w_hd_resp = r_rresp[r_rd_ptr];
    assign w_hd_last = r_rlast[r_rd_ptr];
`endif

    // A bypassed beat counts as a pop for tracking, but it never touches storage.
    assign w_push    = S_RVALID && w_s_ready && !w_bypass;
    assign w_pop     = w_m_valid && M_RREADY;
    assign w_buf_pop = w_pop && !w_bypass;

    assign w_len_full  = (r_len_count == LCW'(LEN_DEPTH));
    assign w_len_empty = (r_len_count == '0);
    assign w_len_push  = len_push && !w_len_full;
    assign w_len_pop   = w_pop && w_hd_last && !w_len_empty;
    assign w_len_exp   = r_len_mem[r_len_rd];

    // RLAST must be set on exactly the beat where beat_cnt reaches the expected ARLEN.
    assign w_err_now = (len_push && w_len_full) ||
                       (w_pop && (w_len_empty || (w_hd_last != (r_beat_cnt == w_len_exp))));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_rid[i]   <= '0;
                r_rdata[i] <= '0;
                r_rresp[i] <= '0;
                r_rlast[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_rid[r_wr_ptr]   <= S_RID;
            r_rdata[r_wr_ptr] <= S_RDATA;
            r_rresp[r_wr_ptr] <= S_RRESP;
            r_rlast[r_wr_ptr] <= S_RLAST;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_buf_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_buf_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < int'(LEN_DEPTH); i++) begin
                r_len_mem[i] <= '0;
            end
            r_len_wr    <= '0;
            r_len_rd    <= '0;
            r_len_count <= '0;
        end else begin
            if (w_len_push) begin
                r_len_mem[r_len_wr] <= len_in;
                r_len_wr            <= r_len_wr + LPW'(1);
            end
            if (w_len_pop) begin
                r_len_rd <= r_len_rd + LPW'(1);
            end
            case ({w_len_push, w_len_pop})
                2'b10:   r_len_count <= r_len_count + LCW'(1);
                2'b01:   r_len_count <= r_len_count - LCW'(1);
                default: r_len_count <= r_len_count;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_beat_cnt <= '0;
            r_last_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= w_hd_last ? '0 : r_beat_cnt + LEN_WIDTH'(1);
            end
            if (w_err_now) begin
                r_last_err <= 1'b1;
            end
        end
    end

    assign S_RREADY = w_s_ready;
    assign M_RVALID = w_m_valid;
    assign M_RID    = w_hd_id;
    assign M_RDATA  = w_hd_data;
    assign M_RRESP  = w_hd_resp;
    assign M_RLAST  = w_hd_last;
    assign len_full = w_len_full;
    assign count    = r_count;
    assign beat_cnt = r_beat_cnt;
    assign last_err = r_last_err;

endmodule

// File: doc/r_fifo.md
Name: r_fifo

Overview:
- Read-data (R channel) return buffer for the AXI crossbar. It is the return path that pairs with the read-address queue.
- Accepts R beats from the slave-side port with a valid/ready handshake, buffers up to DEPTH beats, and presents them in order to the master-side port.
- Tracks burst lengths pushed from the address side and flags any RLAST that disagrees with the expected ARLEN.

Parameters:
- ID_WIDTH, 4, RID width.
- DATA_WIDTH, 32, RDATA width.
- LEN_WIDTH, 4, ARLEN/beat-counter width.
- DEPTH, 4, beat buffer entries; must be a power of two, at least 2.
- LEN_DEPTH, 4, expected-length queue entries; must be a power of two, at least 2.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_RID  in  ID_WIDTH  incoming beat ID.
- S_RDATA  in  DATA_WIDTH  incoming beat data.
- S_RRESP  in  2  incoming beat response.
- S_RLAST  in  1  incoming last-beat marker.
- S_RVALID  in  1  incoming beat valid.
- S_RREADY  out  1  buffer can accept a beat.
- M_RID  out  ID_WIDTH  head beat ID.
- M_RDATA  out  DATA_WIDTH  head beat data.
- M_RRESP  out  2  head beat response.
- M_RLAST  out  1  head beat last marker.
- M_RVALID  out  1  head beat valid.
- M_RREADY  in  1  downstream accepts the head beat.
- len_push  in  1  enqueue an expected burst length.
- len_in  in  LEN_WIDTH  ARLEN of the issued read (beats minus 1).
- len_full  out  1  length queue full.
- count  out  $clog2(DEPTH)+1  beats currently buffered.
- beat_cnt  out  LEN_WIDTH  beats popped so far in the current burst.
- last_err  out  1  sticky burst-length mismatch flag.

Behaviour:
- Reset, asynchronous, while ARESET=1:
  - Pointers, count, beat_cnt, last_err and len queue cleared; storage cleared to 0.
  - M_RVALID=0, S_RREADY=0, len_full=0, all M_R* data outputs 0.
- Push and pop:
  - S_RREADY = !ARESET && (count != DEPTH). Push occurs when S_RVALID && S_RREADY.
  - M_RVALID = (count != 0). M_R* show storage[rd_ptr]. Pop occurs when M_RVALID && M_RREADY.
  - Latency: a beat pushed at edge N is visible on M_R* with M_RVALID=1 after edge N; no same-cycle pass-through.
  - M_R* hold stable while M_RVALID=1 and M_RREADY=0.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count update, $clog2(DEPTH)+1 bits so all DEPTH entries are usable:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full: S_RREADY=0, so no push even if a pop occurs in the same cycle; S_RREADY rises the cycle after the pop.
  - Empty: pop is impossible because M_RVALID=0.
- Length queue:
  - Circular buffer of LEN_DEPTH entries; len_full = (len_count == LEN_DEPTH).
  - len_push while len_full is dropped and sets last_err.
  - A length entry is removed when a beat with M_RLAST=1 pops. Simultaneous len_push and removal leaves len_count unchanged.
- Beat tracking, on each pop:
  - If the length queue is empty: last_err <= 1.
  - Else, with exp = length-queue head:
    - Popped M_RLAST=1 and beat_cnt != exp: last_err <= 1.
    - Popped M_RLAST=0 and beat_cnt == exp: last_err <= 1.
  - Counter update: M_RLAST=1 sets beat_cnt <= 0; otherwise beat_cnt <= beat_cnt+1 (wraps at LEN_WIDTH).
- last_err is sticky until reset. Beats always pass through unmodified regardless of errors.
- Reset asserted mid-burst discards all buffered beats and lengths immediately.

Optional Feature:
- Macro: R_FIFO_BYPASS_EN.
- Defined:
  - When count==0, S_RVALID=1 and M_RREADY=1, the beat goes combinationally from S_R* to M_R* in the same cycle and is not written to storage.
  - M_RVALID = (count!=0) || S_RVALID; when count==0, M_R* mux to S_R*.
  - Beat tracking counts the bypassed beat as a pop.
  - S_RREADY is unchanged (!full).
- Undefined: one-cycle minimum latency as described above; no combinational S_R*-to-M_R* path.

Test Plan:
- Reset, then len_push len_in=3; push 4 beats (RID=2, data 0xA0..0xA3, last on 4th) with M_RREADY=1 -> each beat appears one cycle after its push in order; beat_cnt 0,1,2,3 then 0; last_err=0.
- M_RREADY=0; push 4 beats (DEPTH=4) -> count=4, S_RREADY=0. The 5th beat is held by its source. M_RREADY=1 for one cycle -> count=3, S_RREADY=1 on the next cycle.
- Full FIFO with S_RVALID=1 and M_RREADY=1 in the same cycle -> pop only, count 4->3; then steady push+pop -> count stays at 3.
- len_in=1, push 3 beats with RLAST on the 3rd -> last_err=1 after the 2nd beat pops (beat_cnt==1, RLAST=0); all 3 beats are still delivered intact.
- Pop a beat with the length queue empty -> last_err=1; assert ARESET mid-stream with count=2 -> count=0, M_RVALID=0, last_err=0 immediately.
- R_FIFO_BYPASS_EN defined, empty buffer, S_RVALID=1, M_RREADY=1, data 0x55 -> M_RDATA=0x55 with M_RVALID=1 in the same cycle; count stays 0.
